// File: rtl/demux_1to16_8bit_reg.sv
// rtl/demux_1to16_8bit_reg.sv - registered 1-to-16 demux with a one-entry buffer per channel
// Words are steered by sel into a held channel register; each channel drains via its own valid/ack.
module demux_1to16_8bit_reg #(
  parameter int width = 8,
  parameter int snum  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i,
  input  logic [snum-1:0]  sel,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3,
  output logic [width-1:0] o4,
  output logic [width-1:0] o5,
  output logic [width-1:0] o6,
  output logic [width-1:0] o7,
  output logic [width-1:0] o8,
  output logic [width-1:0] o9,
  output logic [width-1:0] o10,
  output logic [width-1:0] o11,
  output logic [width-1:0] o12,
  output logic [width-1:0] o13,
  output logic [width-1:0] o14,
  output logic [width-1:0] o15,
  output logic [15:0]      o_valid,
  input  logic [15:0]      o_ack,
  output logic             busy
);

  logic [width-1:0] data_q [16];
  logic [width-1:0] data_d [16];
  logic [15:0]      valid_q;
  logic [15:0]      valid_d;
  logic             accept;

  // An ack on the addressed channel frees it in time for a same-cycle refill.
  assign i_ready = !valid_q[sel] || o_ack[sel];
  assign accept  = i_valid && i_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~o_ack;
    if (accept) begin
      data_d[sel]  = i;
      valid_d[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign busy    = |valid_q;

  assign o0  = data_q[0];
  assign o1  = data_q[1];
  assign o2  = data_q[2];
  assign o3  = data_q[3];
  assign o4  = data_q[4];
  assign o5  = data_q[5];
  assign o6  = data_q[6];
  assign o7  = data_q[7];
  assign o8  = data_q[8];
  assign o9  = data_q[9];
  assign o10 = data_q[10];
  assign o11 = data_q[11];
  assign o12 = data_q[12];
  assign o13 = data_q[13];
  assign o14 = data_q[14];
  assign o15 = data_q[15];

endmodule

// File: tb/tb_demux_1to16_8bit_reg.sv
// tb/tb_demux_1to16_8bit_reg.sv - table-driven and randomized bench for demux_1to16_8bit_reg
module tb_demux_1to16_8bit_reg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i;
  logic [3:0]  sel;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  o [16];
  logic [15:0] o_valid;
  logic [15:0] o_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  din;
    logic        iv;
    logic [15:0] ack;
    logic        exp_ready;
    logic [15:0] exp_valid;
    logic [3:0]  chk_ch;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[$];

  // Reference state: one word and one full flag per channel.
  logic [7:0] md [16];
  bit         mv [16];

  demux_1to16_8bit_reg #(.width(8), .snum(4)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .i_valid(i_valid), .i_ready(i_ready),
    .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]), .o4(o[4]), .o5(o[5]), .o6(o[6]), .o7(o[7]),
    .o8(o[8]), .o9(o[9]), .o10(o[10]), .o11(o[11]), .o12(o[12]), .o13(o[13]), .o14(o[14]),
    .o15(o[15]), .o_valid(o_valid), .o_ack(o_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic [7:0] d, input logic v, input logic [15:0] a,
                     input logic er, input logic [15:0] ev, input logic [3:0] ch, input logic [7:0] ed);
    vec_t t;
    t.sel = s; t.din = d; t.iv = v; t.ack = a;
    t.exp_ready = er; t.exp_valid = ev; t.chk_ch = ch; t.exp_data = ed;
    tbl.push_back(t);
  endtask

  function automatic logic [15:0] model_valid();
    logic [15:0] r;
    for (int n = 0; n < 16; n++) r[n] = mv[n];
    return r;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 16; n++) begin
      md[n] = 8'h00;
      mv[n] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " o_valid"}, o_valid, model_valid());
    chk({tag, " busy"}, busy, (model_valid() != 16'h0));
    for (int n = 0; n < 16; n++)
      chk($sformatf("%s o%0d", tag, n), o[n], md[n]);
  endtask

  // One cycle: drive at negedge, check i_ready before the edge, check state after it.
  task automatic step(input logic [3:0] s, input logic [7:0] d, input logic v, input logic [15:0] a,
                      output logic rdy_seen);
    bit rdy_m;
    @(negedge clk);
    sel = s; i = d; i_valid = v; o_ack = a;
    #1;
    rdy_m = !mv[s] || a[s];
    rdy_seen = i_ready;
    chk($sformatf("i_ready sel=%0d", s), i_ready, rdy_m);
    @(posedge clk);
    for (int n = 0; n < 16; n++)
      if (a[n] && mv[n]) mv[n] = 1'b0;
    if (v && rdy_m) begin
      md[s] = d;
      mv[s] = 1'b1;
    end
    #1;
    check_model("model");
  endtask

  initial begin
    logic r;
    logic [15:0] acc;
    rst_n = 1'b0; i = '0; sel = '0; i_valid = 1'b0; o_ack = '0;
    model_clear();

    // Fill, drain, backpressure, spurious ack, mixed stall.
    acc = 16'h0;
    for (int k = 0; k < 16; k++) begin
      acc[k] = 1'b1;
      add(4'(k), 8'hA0 + 8'(k), 1'b1, 16'h0, 1'b1, acc, 4'(k), 8'hA0 + 8'(k));
    end
    add(4'd0, 8'h00, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 4'd4, 8'hA4);
    add(4'd3, 8'hB0, 1'b1, 16'h0000, 1'b1, 16'h0008, 4'd3, 8'hB0);
    add(4'd3, 8'hC0, 1'b1, 16'h0000, 1'b0, 16'h0008, 4'd3, 8'hB0);
    add(4'd3, 8'hC0, 1'b1, 16'h0008, 1'b1, 16'h0008, 4'd3, 8'hC0);
    add(4'd7, 8'hE0, 1'b1, 16'h0020, 1'b1, 16'h0088, 4'd7, 8'hE0);
    add(4'd5, 8'h00, 1'b0, 16'h0000, 1'b1, 16'h0088, 4'd5, 8'hA5);
    add(4'd2, 8'h22, 1'b1, 16'h0000, 1'b1, 16'h008C, 4'd2, 8'h22);
    add(4'd2, 8'h99, 1'b1, 16'h0000, 1'b0, 16'h008C, 4'd2, 8'h22);
    add(4'd9, 8'hD0, 1'b1, 16'h0000, 1'b1, 16'h028C, 4'd9, 8'hD0);
    add(4'd2, 8'h55, 1'b0, 16'h0000, 1'b0, 16'h028C, 4'd2, 8'h22);

    repeat (2) @(posedge clk);
    #1;
    chk("reset o_valid", o_valid, 16'h0000);
    chk("reset busy", busy, 1'b0);
    for (int n = 0; n < 16; n++) chk($sformatf("reset o%0d", n), o[n], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      #0.1;
      chk($sformatf("reset i_ready sel=%0d", s), i_ready, 1'b1);
    end

    foreach (tbl[k]) begin
      step(tbl[k].sel, tbl[k].din, tbl[k].iv, tbl[k].ack, r);
      chk($sformatf("vec%0d i_ready", k), r, tbl[k].exp_ready);
      chk($sformatf("vec%0d o_valid", k), o_valid, tbl[k].exp_valid);
      chk($sformatf("vec%0d busy", k), busy, (tbl[k].exp_valid != 16'h0));
      chk($sformatf("vec%0d data", k), o[tbl[k].chk_ch], tbl[k].exp_data);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic [15:0] a;
      a = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 3) != 0), a, r);
    end

    // Reset pulse between edges must clear everything without a clock edge.
    step(4'd1, 8'h11, 1'b1, 16'h0, r);
    step(4'd6, 8'h66, 1'b1, 16'h0, r);
    @(negedge clk);
    i_valid = 1'b0; o_ack = 16'hFFFF;
    #1 rst_n = 1'b0;
    #1;
    chk("midreset o_valid", o_valid, 16'h0000);
    chk("midreset busy", busy, 1'b0);
    for (int n = 0; n < 16; n++) chk($sformatf("midreset o%0d", n), o[n], 8'h00);
    #1 rst_n = 1'b1;
    model_clear();
    step(4'd12, 8'h3C, 1'b1, 16'h0, r);
    chk("post-reset o12", o[12], 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
